// File: rtl/ipr1_pixsrc_pkg.sv
// Shared definitions for the ipr1 test-pattern pixel source:
// FSM state codes, pattern mode codes and block geometry.
package ipr1_pixsrc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VBLK   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HBLK   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_FLAT    = 2'd0,
        MODE_RAMP    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_BLOCK   = 2'd3
    } mode_t;

    // Moving block and checker squares are BLK_SIZE x BLK_SIZE pixels.
    localparam int BLK_SIZE  = 8;
    localparam int BLK_SHIFT = $clog2(BLK_SIZE);

endpackage

// File: rtl/ipr1_patgen.sv
// Combinational pattern generator: pixel value from the coordinates of the
// pixel about to be presented and the per-frame (shadowed) configuration.
module ipr1_patgen
    import ipr1_pixsrc_pkg::*;
(
    input  logic [9:0] col,
    input  logic [9:0] row,
    input  mode_t      mode,
    input  logic [7:0] bg_level,
    input  logic [7:0] blk_level,
    input  logic [5:0] bx,
    input  logic [5:0] by,
    output logic [7:0] pixel
);

    // Coordinate bits that no pattern looks at.
    logic unused_bits;
    assign unused_bits = ^{col[9], row[9], row[BLK_SHIFT-1:0]};

    // Select the pattern; the block test compares the block-index bits.
    always_comb begin
        pixel = bg_level;
        case (mode)
            MODE_FLAT:    pixel = bg_level;
            MODE_RAMP:    pixel = col[7:0];
            MODE_CHECKER: pixel = (col[BLK_SHIFT] ^ row[BLK_SHIFT]) ? 8'hFF : 8'h00;
            MODE_BLOCK: begin
                if (col[BLK_SHIFT +: 6] == bx && row[BLK_SHIFT +: 6] == by)
                    pixel = blk_level;
                else
                    pixel = bg_level;
            end
            default:      pixel = bg_level;
        endcase
    end

endmodule

// File: rtl/ipr1_pixsrc.sv
// Test-pattern video source: raster timing FSM (IDLE/VBLK/ACTIVE/HBLK) with
// fully registered stream outputs and a per-frame shadowed pattern config.
module ipr1_pixsrc
    import ipr1_pixsrc_pkg::*;
#(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int HBLANK = 16,
    parameter int VBLANK = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [7:0]  bg_level,
    input  logic [7:0]  blk_level,
    input  logic [5:0]  blk_x,
    input  logic [5:0]  blk_y,
    input  logic        auto_move,
    output logic [7:0]  pixelout,
    output logic        frame_valid,
    output logic        data_valid,
    output logic [9:0]  col_cnt,
    output logic [9:0]  row_cnt,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam logic [9:0]  W_LAST  = 10'(IMG_W - 1);
    localparam logic [9:0]  H_LAST  = 10'(IMG_H - 1);
    localparam logic [15:0] HB_LAST = 16'(HBLANK - 1);
    localparam logic [15:0] VB_LAST = 16'(VBLANK - 1);

    state_t      state_reg, state_next;
    logic [15:0] blank_reg, blank_next;
    logic [9:0]  col_reg, col_next;
    logic [9:0]  row_reg, row_next;
    mode_t       mode_sh_reg, mode_sh_next;
    logic [7:0]  bg_sh_reg, bg_sh_next;
    logic [7:0]  blk_sh_reg, blk_sh_next;
    logic        auto_sh_reg, auto_sh_next;
    logic [5:0]  bx_reg, bx_next;
    logic [5:0]  by_reg, by_next;
    logic        frame_valid_reg, frame_valid_next;
    logic        data_valid_reg, data_valid_next;
    logic        frame_done_reg, frame_done_next;
    logic [15:0] frame_cnt_reg, frame_cnt_next;
    logic [7:0]  pixel_reg;
    logic [7:0]  pat_pixel;

    // Pattern is evaluated on the next coordinates/config so the registered
    // pixel lines up with the registered data_valid and counters.
    ipr1_patgen u_patgen (
        .col       (col_next),
        .row       (row_next),
        .mode      (mode_sh_next),
        .bg_level  (bg_sh_next),
        .blk_level (blk_sh_next),
        .bx        (bx_next),
        .by        (by_next),
        .pixel     (pat_pixel)
    );

    // Next-state, counter and config-shadow logic.
    always_comb begin
        state_next      = state_reg;
        blank_next      = blank_reg;
        col_next        = col_reg;
        row_next        = row_reg;
        mode_sh_next    = mode_sh_reg;
        bg_sh_next      = bg_sh_reg;
        blk_sh_next     = blk_sh_reg;
        auto_sh_next    = auto_sh_reg;
        bx_next         = bx_reg;
        by_next         = by_reg;
        frame_done_next = 1'b0;
        frame_cnt_next  = frame_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_VBLK;
                    blank_next = '0;
                end
            end
            ST_VBLK: begin
                if (blank_reg == VB_LAST) begin
                    state_next   = ST_ACTIVE;
                    blank_next   = '0;
                    col_next     = '0;
                    row_next     = '0;
                    mode_sh_next = mode_t'(mode);
                    bg_sh_next   = bg_level;
                    blk_sh_next  = blk_level;
                    auto_sh_next = auto_move;
                    // A run of auto-moving frames starts at blk_x/blk_y and
                    // then steps one block per frame, carrying x into y.
                    if (auto_move && auto_sh_reg) begin
                        {by_next, bx_next} = {by_reg, bx_reg} + 12'd1;
                    end else begin
                        bx_next = blk_x;
                        by_next = blk_y;
                    end
                end else begin
                    blank_next = blank_reg + 16'd1;
                end
            end
            ST_ACTIVE: begin
                if (col_reg == W_LAST) begin
                    blank_next = '0;
                    if (row_reg == H_LAST) begin
                        frame_done_next = 1'b1;
                        frame_cnt_next  = frame_cnt_reg + 16'd1;
                        state_next      = enable ? ST_VBLK : ST_IDLE;
                    end else begin
                        state_next = ST_HBLK;
                    end
                end else begin
                    col_next = col_reg + 10'd1;
                end
            end
            ST_HBLK: begin
                if (blank_reg == HB_LAST) begin
                    state_next = ST_ACTIVE;
                    blank_next = '0;
                    col_next   = '0;
                    row_next   = row_reg + 10'd1;
                end else begin
                    blank_next = blank_reg + 16'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        data_valid_next  = (state_next == ST_ACTIVE);
        frame_valid_next = (state_next == ST_ACTIVE) || (state_next == ST_HBLK);
    end

    // State, counters, shadows and all outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            blank_reg       <= '0;
            col_reg         <= '0;
            row_reg         <= '0;
            mode_sh_reg     <= MODE_FLAT;
            bg_sh_reg       <= '0;
            blk_sh_reg      <= '0;
            auto_sh_reg     <= 1'b0;
            bx_reg          <= '0;
            by_reg          <= '0;
            frame_valid_reg <= 1'b0;
            data_valid_reg  <= 1'b0;
            frame_done_reg  <= 1'b0;
            frame_cnt_reg   <= '0;
            pixel_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            blank_reg       <= blank_next;
            col_reg         <= col_next;
            row_reg         <= row_next;
            mode_sh_reg     <= mode_sh_next;
            bg_sh_reg       <= bg_sh_next;
            blk_sh_reg      <= blk_sh_next;
            auto_sh_reg     <= auto_sh_next;
            bx_reg          <= bx_next;
            by_reg          <= by_next;
            frame_valid_reg <= frame_valid_next;
            data_valid_reg  <= data_valid_next;
            frame_done_reg  <= frame_done_next;
            frame_cnt_reg   <= frame_cnt_next;
            if (data_valid_next)
                pixel_reg <= pat_pixel;
        end
    end

    assign pixelout    = pixel_reg;
    assign frame_valid = frame_valid_reg;
    assign data_valid  = data_valid_reg;
    assign col_cnt     = col_reg;
    assign row_cnt     = row_reg;
    assign frame_done  = frame_done_reg;
    assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_ipr1_pixsrc.sv
// Scoreboard bench for ipr1_pixsrc: stimulus pushes every expected pixel of a
// frame, a monitor pops and compares on each data_valid cycle.
module tb_ipr1_pixsrc;

    localparam int IMG_W  = 512;
    localparam int IMG_H  = 16;
    localparam int HBLANK = 4;
    localparam int VBLANK = 8;
    localparam int FRAME_BUDGET = 20000;
    localparam int NSPOT = 13;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  mode;
    logic [7:0]  bg_level, blk_level;
    logic [5:0]  blk_x, blk_y;
    logic        auto_move;
    logic [7:0]  pixelout;
    logic        frame_valid, data_valid, frame_done;
    logic [9:0]  col_cnt, row_cnt;
    logic [15:0] frame_cnt;

    ipr1_pixsrc #(.IMG_W(IMG_W), .IMG_H(IMG_H), .HBLANK(HBLANK), .VBLANK(VBLANK)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .bg_level(bg_level), .blk_level(blk_level), .blk_x(blk_x), .blk_y(blk_y),
        .auto_move(auto_move), .pixelout(pixelout), .frame_valid(frame_valid),
        .data_valid(data_valid), .col_cnt(col_cnt), .row_cnt(row_cnt),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic [7:0] pix;
    } exp_t;

    typedef struct {
        int         fr;
        int         col;
        int         row;
        logic [7:0] val;
    } spot_t;

    exp_t  sb_q[$];
    spot_t spots[NSPOT];

    int tests = 0;
    int failed = 0;
    int pix_in_frame = 0;
    int exp_fc = 0;
    int frames_seen = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (!ok) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] model_pix(int m, int bg, int bk, int bx, int by, int c, int r);
        case (m)
            0: return 8'(bg);
            1: return 8'(c % 256);
            2: return (((c / 8) % 2) != ((r / 8) % 2)) ? 8'hFF : 8'h00;
            default: return (((c / 8) % 64) == bx && ((r / 8) % 64) == by) ? 8'(bk) : 8'(bg);
        endcase
    endfunction

    task automatic push_frame(input int m, input int bg, input int bk, input int bx, input int by);
        exp_t e;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                e.col = 10'(c);
                e.row = 10'(r);
                e.pix = model_pix(m, bg, bk, bx, by, c, r);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (n < FRAME_BUDGET) begin
            @(negedge clk);
            n++;
            if (frame_done) break;
        end
        check(n < FRAME_BUDGET, name, 64'(n), 64'(FRAME_BUDGET));
        #1;
    endtask

    task automatic wait_pixel(input int r, input int c, input string name);
        int n;
        n = 0;
        while (n < FRAME_BUDGET) begin
            @(negedge clk);
            n++;
            if (data_valid && row_cnt == 10'(r) && col_cnt == 10'(c)) break;
        end
        check(n < FRAME_BUDGET, name, 64'(n), 64'(FRAME_BUDGET));
    endtask

    task automatic measure_start(input string name);
        int n;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (data_valid) break;
        end
        check(n == VBLANK + 1, name, 64'(n), 64'(VBLANK + 1));
    endtask

    // Monitor: pixel/coordinate compare, hand-picked spot values,
    // line-gap length and per-frame completion checks.
    initial begin
        exp_t e;
        int gap;
        bit prev_fd;
        gap = 0;
        prev_fd = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                gap = 0;
                prev_fd = 1'b0;
            end else begin
                if (prev_fd)
                    check(!frame_done, "frame_done_width", 64'(frame_done), 64'd0);
                if (data_valid) begin
                    if (gap != 0) begin
                        check(gap == HBLANK, "hblank_gap", 64'(gap), 64'(HBLANK));
                        gap = 0;
                    end
                    if (sb_q.size() == 0) begin
                        check(1'b0, "sb_underflow", {col_cnt, row_cnt, pixelout}, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check({col_cnt, row_cnt, pixelout, frame_valid} == {e.col, e.row, e.pix, 1'b1},
                              "pixel", {col_cnt, row_cnt, pixelout, frame_valid},
                              {e.col, e.row, e.pix, 1'b1});
                    end
                    for (int i = 0; i < NSPOT; i++) begin
                        if (spots[i].fr == frames_seen && 10'(spots[i].col) == col_cnt &&
                            10'(spots[i].row) == row_cnt)
                            check(pixelout == spots[i].val, "spot_pixel", 64'(pixelout), 64'(spots[i].val));
                    end
                    pix_in_frame++;
                end else if (frame_valid) begin
                    gap++;
                end
                if (frame_done) begin
                    check(pix_in_frame == IMG_W * IMG_H, "frame_pixel_count",
                          64'(pix_in_frame), 64'(IMG_W * IMG_H));
                    check(frame_cnt == 16'(exp_fc + 1), "frame_cnt", 64'(frame_cnt), 64'(exp_fc + 1));
                    check(sb_q.size() == 0, "sb_leftover", 64'(sb_q.size()), 64'd0);
                    exp_fc++;
                    frames_seen++;
                    pix_in_frame = 0;
                    gap = 0;
                end
                prev_fd = frame_done;
            end
        end
    end

    // Directed stimulus.
    initial begin
        bit bad;
        spots[0]  = '{1, 300, 5, 8'h2C};
        spots[1]  = '{1, 255, 0, 8'hFF};
        spots[2]  = '{2, 8, 0, 8'hFF};
        spots[3]  = '{2, 8, 8, 8'h00};
        spots[4]  = '{2, 0, 0, 8'h00};
        spots[5]  = '{3, 504, 0, 8'hC0};
        spots[6]  = '{3, 511, 7, 8'hC0};
        spots[7]  = '{3, 503, 0, 8'h20};
        spots[8]  = '{3, 504, 8, 8'h20};
        spots[9]  = '{4, 0, 8, 8'hC0};
        spots[10] = '{4, 7, 15, 8'hC0};
        spots[11] = '{4, 504, 0, 8'h20};
        spots[12] = '{4, 8, 8, 8'h20};

        reset_n = 1'b0; enable = 1'b0; mode = 2'd0; bg_level = 8'h00; blk_level = 8'h00;
        blk_x = 6'd0; blk_y = 6'd0; auto_move = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check({pixelout, frame_valid, data_valid, col_cnt, row_cnt, frame_done, frame_cnt} == '0,
              "reset_state", {pixelout, frame_valid, data_valid, col_cnt, row_cnt, frame_done, frame_cnt}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk); #1;
        check(!data_valid && !frame_valid, "idle_no_enable", {data_valid, frame_valid}, 64'd0);

        // Frame 0: flat 0x40
        mode = 2'd0; bg_level = 8'h40; blk_level = 8'hC0;
        push_frame(0, 8'h40, 8'hC0, 0, 0);
        enable = 1'b1;
        measure_start("start_latency");
        wait_done("done_flat");

        // Frame 1: ramp
        mode = 2'd1;
        push_frame(1, 8'h40, 8'hC0, 0, 0);
        wait_done("done_ramp");

        // Frame 2: checker
        mode = 2'd2;
        push_frame(2, 8'h40, 8'hC0, 0, 0);
        wait_done("done_checker");

        // Frame 3: moving block starting at (63,0)
        mode = 2'd3; bg_level = 8'h20; blk_level = 8'hC0;
        blk_x = 6'd63; blk_y = 6'd0; auto_move = 1'b1;
        push_frame(3, 8'h20, 8'hC0, 63, 0);
        wait_done("done_block1");

        // Frame 4: block wrapped to (0,1); enable dropped mid-frame
        push_frame(3, 8'h20, 8'hC0, 0, 1);
        wait_pixel(8, 0, "reach_row8");
        enable = 1'b0;
        wait_done("done_block2");
        bad = 1'b0;
        for (int i = 0; i < 5 * VBLANK; i++) begin
            @(negedge clk);
            if (data_valid || frame_valid || frame_done) bad = 1'b1;
        end
        check(!bad, "idle_after_disable", 64'(bad), 64'd0);
        check(frame_cnt == 16'd5, "frame_cnt_idle", 64'(frame_cnt), 64'd5);

        // Frame 5: fixed block at (2,1), aborted by reset mid-line
        #1;
        mode = 2'd3; bg_level = 8'h10; blk_level = 8'hE0;
        blk_x = 6'd2; blk_y = 6'd1; auto_move = 1'b0;
        push_frame(3, 8'h10, 8'hE0, 2, 1);
        enable = 1'b1;
        wait_pixel(3, 100, "reach_midline");
        #2;
        reset_n = 1'b0;
        #1;
        check({pixelout, frame_valid, data_valid, col_cnt, row_cnt, frame_done, frame_cnt} == '0,
              "reset_midline", {pixelout, frame_valid, data_valid, col_cnt, row_cnt, frame_done, frame_cnt}, 64'd0);
        sb_q.delete();
        pix_in_frame = 0;
        exp_fc = 0;
        repeat (4) @(negedge clk);
        check(!frame_done && frame_cnt == 16'd0, "no_done_in_reset", {frame_done, frame_cnt}, 64'd0);

        // Frame after reset: flat 0x11, must wait a full VBLANK
        #1;
        mode = 2'd0; bg_level = 8'h11;
        push_frame(0, 8'h11, 8'hE0, 0, 0);
        reset_n = 1'b1;
        measure_start("restart_latency");
        wait_done("done_after_reset");

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ipr1_pixsrc.md
IPR1_PIXSRC -- requirements
Module: ipr1_pixsrc

Interface
REQ-001 SHALL have parameter IMG_W, default 512, active pixels per line.
REQ-002 SHALL have parameter IMG_H, default 512, active lines per frame.
REQ-003 SHALL have parameter HBLANK, default 16, idle cycles between lines (>=1).
REQ-004 SHALL have parameter VBLANK, default 64, idle cycles between frames (>=1).
REQ-005 SHALL have port clk  in  1  the only clock; all logic on rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port enable  in  1  run request; sampled at frame boundaries.
REQ-008 SHALL have port mode  in  2  pattern: 0 flat, 1 ramp, 2 checker, 3 moving block.
REQ-009 SHALL have port bg_level  in  8  background/flat pixel value.
REQ-010 SHALL have port blk_level  in  8  pixel value inside the moving block.
REQ-011 SHALL have port blk_x, blk_y  in  6 each  initial moving-block position, in 8x8-block units.
REQ-012 SHALL have port auto_move  in  1  advance block position by one block per frame.
REQ-013 SHALL have port pixelout  out  8  pixel value.
REQ-014 SHALL have port frame_valid, data_valid  out  1 each  stream qualifiers, same meaning as on motion-trigger consumers.
REQ-015 SHALL have port col_cnt, row_cnt  out  10 each  coordinates of the current pixel.
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse after the last pixel of a frame.
REQ-017 SHALL have port frame_cnt  out  16  frames completed, wraps 65535->0.

Function
REQ-018 SHALL implement FSM IDLE, VBLK, ACTIVE, HBLK; every output registered.
REQ-019 IDLE: when enable=1, go to VBLK; frame_valid=0, data_valid=0.
REQ-020 VBLK: count VBLANK cycles, then go to ACTIVE at row 0, col 0; frame_valid=0.
REQ-021 ACTIVE: data_valid=1 for IMG_W consecutive cycles; col_cnt 0..IMG_W-1.
REQ-022 After the last column, go to HBLK if row<IMG_H-1, otherwise end the frame.
REQ-023 HBLK: data_valid=0, frame_valid=1 for HBLANK cycles, then ACTIVE with row+1.
REQ-024 frame_valid=1 from the first active pixel through the last active pixel, including HBLK.
REQ-025 Frame end: frame_done=1 for one cycle, frame_cnt+1, then VBLK if enable=1, else IDLE.
REQ-026 Deasserting enable mid-frame SHALL NOT truncate the frame.
REQ-027 mode, levels, blk_x/blk_y and auto_move SHALL be shadowed on VBLK->ACTIVE; they stay constant within a frame.
REQ-028 Patterns: flat=bg_level; ramp=col_cnt[7:0]; checker=0xFF if col[3]^row[3], else 0x00.
REQ-029 Moving block: blk_level where col[8:3]==bx and row[8:3]==by, else bg_level.
REQ-030 Position (bx,by) loads from blk_x/blk_y when auto_move=0.
REQ-031 With auto_move=1, bx increments by 1 per frame; 63->0 wraps bx and increments by, which wraps 63->0.
REQ-032 pixelout, col_cnt and row_cnt SHALL be aligned in the same cycle as data_valid=1; they hold their last value when data_valid=0.

Reset
REQ-033 reset_n=0 SHALL immediately force IDLE and all outputs and counters to 0, including frame_cnt, bx and by.
REQ-034 Reset mid-frame SHALL abort the frame without a frame_done pulse.
REQ-035 After release, the first frame SHALL start only after a full VBLANK.

Structure
REQ-036 A shared package SHALL hold the FSM state encodings, pattern mode codes and the block size constant (8).
REQ-037 The pattern generator SHALL be one sub-module, ipr1_patgen: combinational pixel from (col, row, shadowed config), registered in the parent.

Verification
REQ-038 Reset, then enable=1, mode=0, bg_level=0x40 -> after 64 idle cycles, 512 data_valid cycles of pixelout 0x40, then 16 gap cycles with frame_valid=1.
REQ-039 Full frame -> exactly 262144 data_valid cycles; frame_done pulses once; frame_cnt=1.
REQ-040 mode=1 -> pixelout equals col_cnt mod 256 (col 300 -> 0x2C). mode=2 -> (col 8,row 0)=0xFF and (col 8,row 8)=0x00.
REQ-041 mode=3, blk_x=63, blk_y=5, auto_move=1 -> frame 1 block at cols 504-511, rows 40-47; frame 2 block at cols 0-7, rows 48-55.
REQ-042 enable dropped at row 100 -> frame completes to row 511, then IDLE; reset_n low mid-line -> outputs 0 the same cycle, no frame_done.
REQ-043 Motion-trigger consumer loopback: static mode 0 -> trigger stays 0; mode 3 with auto_move=1 and small threshold -> trigger asserts.
